// File: rtl/mvm_par_sat_if.sv
// Command, load-data and result signals shared between a host and the mvm_par_sat
// matrix-vector multiplier.
interface mvm_par_sat_if #(
  parameter int unsigned B     = 8,
  parameter int unsigned OUT_W = 2 * B
);
  logic                    loadMatrix;
  logic                    loadVector;
  logic                    start;
  logic signed [B-1:0]     data_in;
  logic                    busy;
  logic                    done;
  logic signed [OUT_W-1:0] data_out;
  logic                    out_valid;
  logic                    sat_flag;

  modport master (
    output loadMatrix, loadVector, start, data_in,
    input  busy, done, data_out, out_valid, sat_flag
  );

  modport slave (
    input  loadMatrix, loadVector, start, data_in,
    output busy, done, data_out, out_valid, sat_flag
  );
endinterface

// File: rtl/mvm_par_sat.sv
// Signed K x K matrix-vector multiplier with P parallel MAC lanes, serial operand load
// and a K-word result drain with optional output saturation.
module mvm_par_sat #(
  parameter int unsigned K     = 16,
  parameter int unsigned B     = 8,
  parameter int unsigned P     = 4,
  parameter bit          SAT   = 1'b1,
  parameter int unsigned OUT_W = 2 * B
) (
  input logic          clk,
  input logic          reset,
  mvm_par_sat_if.slave bus
);
  localparam int unsigned ACC_W = 2 * B + $clog2(K);
  localparam int unsigned CPR   = K / P;
  localparam int unsigned MW    = $clog2(K * K);
  localparam int unsigned KW    = $clog2(K);
  localparam int unsigned RW    = $clog2(K + 1);
  localparam int unsigned CW    = (CPR > 1) ? $clog2(CPR) : 1;

  localparam longint OutMaxL = (longint'(1) << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] OutMax = ACC_W'(OutMaxL);
  localparam logic signed [ACC_W-1:0] OutMin = ACC_W'(-OutMaxL - 1);

  if ((K % P) != 0) begin : g_bad_lanes
    $error("mvm_par_sat: K must be a multiple of P");
  end

  typedef enum logic [2:0] {StIdle, StLoadM, StLoadV, StCompute, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [MW-1:0]           cnt_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           chunk_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, lane_sum;
  logic signed [B-1:0]     mat_q [K*K];
  logic signed [B-1:0]     vec_q [K];
  logic signed [OUT_W-1:0] res_q [K];
  logic                    rflag_q [K];
  logic signed [OUT_W-1:0] conv;
  logic                    fits;
  logic                    done_q, valid_q, sat_q;
  logic signed [OUT_W-1:0] dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.loadMatrix)      state_d = StLoadM;
        else if (bus.loadVector) state_d = StLoadV;
        else if (bus.start)      state_d = StCompute;
      end
      StLoadM:   if (cnt_q == MW'(K * K - 1)) state_d = StIdle;
      StLoadV:   if (cnt_q == MW'(K - 1)) state_d = StIdle;
      // row_q == K marks the extra cycle that raises done and primes the drain
      StCompute: if (row_q == RW'(K)) state_d = StDrain;
      StDrain:   if (cnt_q == MW'(K - 1)) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.done      = done_q;
    bus.out_valid = valid_q;
    bus.sat_flag  = sat_q;
    bus.data_out  = dout_q;
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < P; l++) begin
      lane_sum = lane_sum + ACC_W'(
          (2 * B)'(mat_q[MW'(int'(row_q) * K + int'(chunk_q) * P + l)]) *
          (2 * B)'(vec_q[KW'(int'(chunk_q) * P + l)]));
    end
    acc_d = ((chunk_q == '0) ? '0 : acc_q) + lane_sum;
    fits  = (acc_d <= OutMax) && (acc_d >= OutMin);
    if (SAT && !fits) conv = acc_d[ACC_W-1] ? OutMin[OUT_W-1:0] : OutMax[OUT_W-1:0];
    else              conv = acc_d[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      row_q   <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      dout_q  <= '0;
      for (int i = 0; i < K * K; i++) mat_q[i] <= '0;
      for (int i = 0; i < K; i++) begin
        vec_q[i]   <= '0;
        res_q[i]   <= '0;
        rflag_q[i] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q   <= '0;
          row_q   <= '0;
          chunk_q <= '0;
        end
        StLoadM: begin
          mat_q[cnt_q] <= bus.data_in;
          cnt_q        <= cnt_q + 1'b1;
        end
        StLoadV: begin
          vec_q[cnt_q[KW-1:0]] <= bus.data_in;
          cnt_q                <= cnt_q + 1'b1;
        end
        StCompute: begin
          if (row_q != RW'(K)) begin
            acc_q <= acc_d;
            if (chunk_q == CW'(CPR - 1)) begin
              res_q[row_q[KW-1:0]]   <= conv;
              rflag_q[row_q[KW-1:0]] <= !fits;
              chunk_q                <= '0;
              row_q                  <= row_q + 1'b1;
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end else begin
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            dout_q  <= res_q[0];
            sat_q   <= rflag_q[0];
            cnt_q   <= '0;
          end
        end
        StDrain: begin
          if (cnt_q == MW'(K - 1)) begin
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            dout_q <= res_q[KW'(cnt_q + 1'b1)];
            sat_q  <= rflag_q[KW'(cnt_q + 1'b1)];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
